// File: rtl/brick_pkg.sv
// Shared brick-grid geometry and FSM encoding for the collision tracker and the brick renderer.
package brick_pkg;

  localparam int NUM_COLS   = 5;
  localparam int NUM_ROWS   = 2;
  localparam int BRICK_W    = 124;
  localparam int BRICK_H    = 20;
  localparam int PITCH_X    = 128;
  localparam int PITCH_Y    = 24;
  localparam int BALL_SIZE  = 8;
  localparam int SCORE_W    = 8;

  localparam int NUM_BRICKS = NUM_COLS * NUM_ROWS;
  localparam int IDX_W      = 4;
  // One bit wider than the 10-bit ball coordinates so that ball+size never wraps.
  localparam int COORD_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic logic [COORD_W-1:0] brick_x(input logic [IDX_W-1:0] idx);
    return COORD_W'((int'(idx) % NUM_COLS) * PITCH_X);
  endfunction

  function automatic logic [COORD_W-1:0] brick_y(input logic [IDX_W-1:0] idx);
    return COORD_W'((int'(idx) / NUM_COLS) * PITCH_Y);
  endfunction

endpackage

// File: rtl/brick_hit_test.sv
// Combinational ball-vs-brick overlap test, plus whether the ball centre x lies in the brick's x span.
module brick_hit_test
  import brick_pkg::*;
(
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [9:0]         i_ball_x,
  input  logic [9:0]         i_ball_y,
  output logic               o_overlap,
  output logic               o_centre_in
);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_x_end;
  logic [COORD_W-1:0] w_y_end;
  logic [COORD_W-1:0] w_bx_end;
  logic [COORD_W-1:0] w_by_end;
  logic [COORD_W-1:0] w_centre;

  assign w_x      = COORD_W'(i_ball_x);
  assign w_y      = COORD_W'(i_ball_y);
  assign w_x_end  = w_x + COORD_W'(BALL_SIZE);
  assign w_y_end  = w_y + COORD_W'(BALL_SIZE);
  assign w_bx_end = i_bx + COORD_W'(BRICK_W);
  assign w_by_end = i_by + COORD_W'(BRICK_H);
  assign w_centre = w_x + COORD_W'(BALL_SIZE / 2);

  assign o_overlap   = (w_x < w_bx_end) && (w_x_end > i_bx) &&
                       (w_y < w_by_end) && (w_y_end > i_by);
  assign o_centre_in = (w_centre >= i_bx) && (w_centre < w_bx_end);

endmodule

// File: rtl/brick_collision_tracker.sv
// Per-frame brick collision scanner and owner of the brick alive flags.
// Optional macro BRICK_TWO_HIT_EN: bricks crack on the first hit and break on the second.
module brick_collision_tracker
  import brick_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_frame_tick,
  input  logic                  i_new_level,
  input  logic [9:0]            i_ball_x,
  input  logic [9:0]            i_ball_y,
  output logic [NUM_BRICKS-1:0] o_alive,
  output logic                  o_bounce_x,
  output logic                  o_bounce_y,
  output logic [3:0]            o_hit_index,
  output logic [SCORE_W-1:0]    o_score,
  output logic                  o_all_clear,
  output logic                  o_busy
`ifdef BRICK_TWO_HIT_EN
  ,
  output logic [NUM_BRICKS-1:0] o_cracked
`endif
);

  state_t                r_state;
  state_t                w_next_state;
  logic [NUM_BRICKS-1:0] r_alive;
  logic [SCORE_W-1:0]    r_score;
  logic [3:0]            r_hit_index;
  logic                  r_bounce_x;
  logic                  r_bounce_y;
  logic [9:0]            r_ball_x;
  logic [9:0]            r_ball_y;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_found;
  logic [IDX_W-1:0]      r_found_idx;
  logic                  r_found_centre;
  logic                  w_overlap;
  logic                  w_centre_in;
`ifdef BRICK_TWO_HIT_EN
  logic [NUM_BRICKS-1:0] r_cracked;
`endif

  brick_hit_test u_hit_test (
    .i_bx        (brick_x(r_idx)),
    .i_by        (brick_y(r_idx)),
    .i_ball_x    (r_ball_x),
    .i_ball_y    (r_ball_y),
    .o_overlap   (w_overlap),
    .o_centre_in (w_centre_in)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so that no path through the case leaves w_next_state unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_frame_tick) w_next_state = ST_SCAN;
      ST_SCAN:    if (r_idx == IDX_W'(NUM_BRICKS - 1)) w_next_state = ST_RESPOND;
      ST_RESPOND: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
    if (i_new_level) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alive        <= '1;
      r_score        <= '0;
      r_hit_index    <= '0;
      r_bounce_x     <= 1'b0;
      r_bounce_y     <= 1'b0;
      r_ball_x       <= '0;
      r_ball_y       <= '0;
      r_idx          <= '0;
      r_found        <= 1'b0;
      r_found_idx    <= '0;
      r_found_centre <= 1'b0;
`ifdef BRICK_TWO_HIT_EN
      r_cracked      <= '0;
`endif
    end else begin
      r_bounce_x <= 1'b0;
      r_bounce_y <= 1'b0;
      if (i_new_level) begin
        r_alive <= '1;
        r_found <= 1'b0;
`ifdef BRICK_TWO_HIT_EN
        r_cracked <= '0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_frame_tick) begin
              r_ball_x <= i_ball_x;
              r_ball_y <= i_ball_y;
              r_idx    <= '0;
              r_found  <= 1'b0;
            end
          end
          ST_SCAN: begin
            // Lowest index wins: later hits in the same scan are ignored.
            if (w_overlap && r_alive[r_idx] && !r_found) begin
              r_found        <= 1'b1;
              r_found_idx    <= r_idx;
              r_found_centre <= w_centre_in;
            end
            r_idx <= r_idx + 1'b1;
          end
          ST_RESPOND: begin
            if (r_found) begin
              if (r_found_centre) r_bounce_y <= 1'b1;
              else                r_bounce_x <= 1'b1;
`ifdef BRICK_TWO_HIT_EN
              if (r_cracked[r_found_idx]) begin
                r_alive[r_found_idx] <= 1'b0;
                r_hit_index          <= r_found_idx;
                if (r_score != '1) r_score <= r_score + 1'b1;
              end else begin
                r_cracked[r_found_idx] <= 1'b1;
              end
`else
              r_alive[r_found_idx] <= 1'b0;
              r_hit_index          <= r_found_idx;
              if (r_score != '1) r_score <= r_score + 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_alive     = r_alive;
  assign o_bounce_x  = r_bounce_x;
  assign o_bounce_y  = r_bounce_y;
  assign o_hit_index = r_hit_index;
  assign o_score     = r_score;
  assign o_all_clear = (r_alive == '0);
  assign o_busy      = (r_state != ST_IDLE);
`ifdef BRICK_TWO_HIT_EN
  assign o_cracked   = r_cracked;
`endif

endmodule

// File: tb/tb_brick_collision_tracker.sv
// Self-checking bench for brick_collision_tracker (default build): vector table, corner sequences, random frames vs. a model.
module tb_brick_collision_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_new_level = 1'b0;
  logic [9:0] i_ball_x = '0;
  logic [9:0] i_ball_y = '0;
  logic [9:0] o_alive;
  logic       o_bounce_x;
  logic       o_bounce_y;
  logic [3:0] o_hit_index;
  logic [7:0] o_score;
  logic       o_all_clear;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  // Reference state, derived from the brick rules only.
  logic [9:0] m_alive;
  int         m_score;
  int         m_hit;

  brick_collision_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (i_frame_tick),
    .i_new_level  (i_new_level),
    .i_ball_x     (i_ball_x),
    .i_ball_y     (i_ball_y),
    .o_alive      (o_alive),
    .o_bounce_x   (o_bounce_x),
    .o_bounce_y   (o_bounce_y),
    .o_hit_index  (o_hit_index),
    .o_score      (o_score),
    .o_all_clear  (o_all_clear),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    bit         rst_first;
    logic [9:0] alive;
    int         score;
    int         hidx;
    int         nbx;
    int         nby;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_new_level();
    @(negedge clk);
    i_new_level = 1'b1;
    @(negedge clk);
    i_new_level = 1'b0;
  endtask

  // Grid rules evaluated brick by brick with plain integers.
  task automatic model_frame(input int x, input int y, output int ebx, output int eby);
    bit done;
    int bx, by;
    ebx = 0;
    eby = 0;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bx = (k % 5) * 128;
      by = (k / 5) * 24;
      if (!done && m_alive[k] && x < bx + 124 && x + 8 > bx && y < by + 20 && y + 8 > by) begin
        done = 1'b1;
        m_alive[k] = 1'b0;
        m_score = (m_score >= 255) ? 255 : m_score + 1;
        m_hit = k;
        if (x + 4 >= bx && x + 4 < bx + 124) eby = 1;
        else ebx = 1;
      end
    end
  endtask

  // Issues one frame_tick and watches 14 cycles; outputs must change exactly 12 cycles later.
  task automatic frame_and_check(input string tag, input int x, input int y, input logic [9:0] pre_alive,
                                 input logic [9:0] ea, input int es, input int eh, input int ebx, input int eby);
    int nbx, nby, late;
    nbx = 0; nby = 0; late = 0;
    @(negedge clk);
    i_frame_tick = 1'b1;
    i_ball_x = 10'(x);
    i_ball_y = 10'(y);
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) begin
        i_frame_tick = 1'b0;
        i_ball_x = 10'($urandom_range(0, 1023));
        i_ball_y = 10'($urandom_range(0, 1023));
      end
      if (o_bounce_x) begin nbx++; if (n != 12) late++; end
      if (o_bounce_y) begin nby++; if (n != 12) late++; end
      if (n == 11) begin
        check({tag, " alive_before_latency"}, 32'(o_alive), 32'(pre_alive));
        check({tag, " busy_in_scan"}, 32'(o_busy), 32'd1);
      end
      if (n == 12) begin
        check({tag, " alive"}, 32'(o_alive), 32'(ea));
        check({tag, " score"}, 32'(o_score), 32'(es));
        check({tag, " hit_index"}, 32'(o_hit_index), 32'(eh));
        check({tag, " busy_after"}, 32'(o_busy), 32'd0);
        check({tag, " all_clear"}, 32'(o_all_clear), 32'(ea == 10'h0));
      end
    end
    check({tag, " bounce_x_count"}, 32'(nbx), 32'(ebx));
    check({tag, " bounce_y_count"}, 32'(nby), 32'(eby));
    check({tag, " pulse_timing"}, 32'(late), 32'd0);
  endtask

  initial begin
    logic [9:0] prev;
    logic [9:0] pre;
    int ebx, eby, nbx, nby;

    vecs[0] = '{x: 130, y: 10,  rst_first: 1, alive: 10'h3FD, score: 1, hidx: 1, nbx: 0, nby: 1};
    vecs[1] = '{x: 122, y: 5,   rst_first: 1, alive: 10'h3FE, score: 1, hidx: 0, nbx: 1, nby: 0};
    vecs[2] = '{x: 300, y: 100, rst_first: 0, alive: 10'h3FE, score: 1, hidx: 0, nbx: 0, nby: 0};
    vecs[3] = '{x: 5,   y: 30,  rst_first: 0, alive: 10'h3DE, score: 2, hidx: 5, nbx: 0, nby: 1};
    vecs[4] = '{x: 124, y: 0,   rst_first: 0, alive: 10'h3DC, score: 3, hidx: 1, nbx: 0, nby: 1};
    vecs[5] = '{x: 120, y: 0,   rst_first: 0, alive: 10'h3DC, score: 3, hidx: 1, nbx: 0, nby: 0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset alive", 32'(o_alive), 32'h3FF);
    check("reset score", 32'(o_score), 32'd0);
    check("reset hit_index", 32'(o_hit_index), 32'd0);
    check("reset all_clear", 32'(o_all_clear), 32'd0);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset bounce", 32'({o_bounce_x, o_bounce_y}), 32'd0);

    // Directed vector table
    prev = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst_first) begin
        do_reset();
        prev = 10'h3FF;
      end
      frame_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, prev, vecs[i].alive,
                      vecs[i].score, vecs[i].hidx, vecs[i].nbx, vecs[i].nby);
      prev = vecs[i].alive;
    end

    // frame_tick during a scan is dropped; ball inputs moving mid-scan have no effect
    do_reset();
    nbx = 0; nby = 0;
    @(negedge clk);
    i_frame_tick = 1'b1; i_ball_x = 10'd130; i_ball_y = 10'd10;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (n == 1) begin i_frame_tick = 1'b0; i_ball_x = 10'd5; i_ball_y = 10'd30; end
      if (n == 3) i_frame_tick = 1'b1;
      if (n == 4) i_frame_tick = 1'b0;
      if (o_bounce_x) nbx++;
      if (o_bounce_y) nby++;
      if (n == 13) check("busy_ignore busy_after", 32'(o_busy), 32'd0);
    end
    check("busy_ignore alive", 32'(o_alive), 32'h3FD);
    check("busy_ignore score", 32'(o_score), 32'd1);
    check("busy_ignore bounce_x", 32'(nbx), 32'd0);
    check("busy_ignore bounce_y", 32'(nby), 32'd1);

    // Reset mid-scan wins, score returns to 0 and no pulse follows
    nbx = 0; nby = 0;
    @(negedge clk);
    i_frame_tick = 1'b1; i_ball_x = 10'd5; i_ball_y = 10'd30;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) i_frame_tick = 1'b0;
      if (n == 5) rst = 1'b1;
      if (n == 6) begin
        rst = 1'b0;
        check("mid_rst busy", 32'(o_busy), 32'd0);
        check("mid_rst alive", 32'(o_alive), 32'h3FF);
        check("mid_rst score", 32'(o_score), 32'd0);
      end
      if (o_bounce_x) nbx++;
      if (o_bounce_y) nby++;
    end
    check("mid_rst pulses", 32'(nbx + nby), 32'd0);
    check("mid_rst alive_end", 32'(o_alive), 32'h3FF);

    // new_level aborts a scan; new_level together with frame_tick starts nothing
    nbx = 0; nby = 0;
    @(negedge clk);
    i_frame_tick = 1'b1; i_ball_x = 10'd130; i_ball_y = 10'd10;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 1) i_frame_tick = 1'b0;
      if (n == 4) i_new_level = 1'b1;
      if (n == 5) begin
        i_new_level = 1'b0;
        check("abort busy", 32'(o_busy), 32'd0);
      end
      if (o_bounce_x) nbx++;
      if (o_bounce_y) nby++;
    end
    check("abort pulses", 32'(nbx + nby), 32'd0);
    check("abort alive", 32'(o_alive), 32'h3FF);
    @(negedge clk);
    i_frame_tick = 1'b1; i_new_level = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0; i_new_level = 1'b0;
    check("tick_with_new_level busy", 32'(o_busy), 32'd0);

    // Clear every brick, then new_level restores the grid and keeps the score
    do_reset();
    m_alive = 10'h3FF; m_score = 0; m_hit = 0;
    for (int k = 0; k < 10; k++) begin
      pre = m_alive;
      model_frame((k % 5) * 128 + 58, (k / 5) * 24 + 6, ebx, eby);
      frame_and_check($sformatf("clear%0d", k), (k % 5) * 128 + 58, (k / 5) * 24 + 6, pre,
                      m_alive, m_score, m_hit, ebx, eby);
    end
    check("clear all_clear", 32'(o_all_clear), 32'd1);
    check("clear score", 32'(o_score), 32'd10);
    pulse_new_level();
    m_alive = 10'h3FF;
    check("new_level alive", 32'(o_alive), 32'h3FF);
    check("new_level all_clear", 32'(o_all_clear), 32'd0);
    check("new_level score", 32'(o_score), 32'd10);

    // Random frames against the model
    for (int i = 0; i < 40; i++) begin
      int x, y;
      if (m_alive == 10'h0) begin
        pulse_new_level();
        m_alive = 10'h3FF;
      end
      x = $urandom_range(0, 660);
      y = $urandom_range(0, 56);
      pre = m_alive;
      model_frame(x, y, ebx, eby);
      frame_and_check($sformatf("rand%0d(%0d,%0d)", i, x, y), x, y, pre, m_alive, m_score, m_hit, ebx, eby);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brick_collision_tracker.md
Name: brick_collision_tracker

Overview:
- Owns the per-brick alive state that the brick renderer consumes; it is the writer of the alive flags.
- Once per frame it scans the 5x2 brick grid against the ball bounding box and clears the first brick hit (lowest index). It then pulses a bounce request to the ball controller and increments the score.
- Sits between the ball/paddle logic and the brick renderer. The alive vector maps bit i to renderer input alive(i+1).

Parameters:
- NUM_COLS, 5, bricks per row
- NUM_ROWS, 2, rows of bricks
- BRICK_W, 124, brick width in pixels
- BRICK_H, 20, brick height in pixels
- PITCH_X, 128, horizontal brick-to-brick pitch
- PITCH_Y, 24, vertical row-to-row pitch
- BALL_SIZE, 8, ball square side in pixels
- SCORE_W, 8, score counter width

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame; starts a scan
- new_level  in  1  one-cycle pulse; restores all bricks
- ball_x  in  10  ball top-left x
- ball_y  in  10  ball top-left y
- alive  out  NUM_COLS*NUM_ROWS  brick alive flags; bit = row*NUM_COLS+col
- bounce_x  out  1  one-cycle pulse: reverse ball x velocity
- bounce_y  out  1  one-cycle pulse: reverse ball y velocity
- hit_index  out  4  index of the last brick cleared
- score  out  SCORE_W  bricks destroyed since reset
- all_clear  out  1  high while alive == 0
- busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (sync, rst=1 at a clk edge): alive = all ones, score = 0, hit_index = 0, bounce_x = 0, bounce_y = 0, busy = 0, FSM = IDLE. Reset wins over every other input.
- Brick geometry: brick k has col = k mod NUM_COLS and row = k / NUM_COLS.
  - bx = col*PITCH_X, by = row*PITCH_Y.
  - The span is [bx, bx+BRICK_W) x [by, by+BRICK_H).
- Overlap test uses 11-bit arithmetic so that ball_x+BALL_SIZE never wraps. A hit requires all of:
  - ball_x < bx+BRICK_W
  - ball_x+BALL_SIZE > bx
  - ball_y < by+BRICK_H
  - ball_y+BALL_SIZE > by
  - alive[k] = 1
- FSM states: IDLE, SCAN, RESPOND.
- IDLE:
  - frame_tick=1 latches ball_x/ball_y and sets idx = 0 and found = 0.
  - Next state is SCAN.
- SCAN: evaluates one brick per cycle at idx.
  - On the first hit, record the index and set found = 1. Later hits in the same scan are ignored.
  - After idx = NUM_COLS*NUM_ROWS-1, go to RESPOND.
  - A scan therefore takes exactly 10 cycles.
- RESPOND: one cycle, then return to IDLE. If found:
  - alive[hit] is cleared.
  - hit_index is updated.
  - score increments, saturating at all ones.
  - Exactly one of bounce_x or bounce_y pulses for one cycle. bounce_y fires if the ball centre x (ball_x + BALL_SIZE/2) lies in [bx, bx+BRICK_W); otherwise bounce_x fires.
- Latency: frame_tick at cycle t gives registered outputs visible at cycle t+12.
- frame_tick while busy: ignored, with no queuing.
- Ball inputs changing mid-scan: no effect, because they were latched at frame_tick.
- new_level:
  - Sets alive to all ones and aborts any scan (FSM returns to IDLE with no pulses).
  - Score is kept.
  - If new_level and frame_tick arrive together, new_level wins and no scan starts.
- all_clear is a combinational decode of the alive register.

Optional Feature:
- Macro: BRICK_TWO_HIT_EN.
- With the macro defined:
  - An extra register cracked (same width as alive, reset to 0, cleared by new_level) is added, with a matching output port cracked.
  - The first hit on a brick sets cracked[k], pulses the bounce, and does not score; alive stays 1.
  - A hit on a cracked brick clears alive[k] and scores 1.
- Without the macro: the cracked port and register are absent, and every hit clears alive immediately.

Decomposition:
- Shared package brick_pkg holds NUM_COLS, NUM_ROWS, BRICK_W, BRICK_H, PITCH_X and PITCH_Y. The renderer and this block take the grid geometry from this single source.
- The package also holds the FSM state encoding.
- Sub-module brick_hit_test: purely combinational overlap and centre-in-span test for one brick, given bx, by and the ball position. It is instantiated once and time-multiplexed by idx.

Test Plan:
- Reset check: after rst, alive=10'h3FF, score=0, all_clear=0, busy=0, no bounce pulses.
- Ball (130,10), frame_tick:
  - At t+12, alive=10'h3FD, hit_index=1, score=1.
  - bounce_y pulses for 1 cycle (centre 134 lies within [128,252)).
- Ball (122,5) straddling bricks 0 and 1:
  - Only brick 0 is cleared (alive=10'h3FE) and score increments by 1.
  - Centre 126 lies outside [0,124), so bounce_x pulses.
- Ball (300,100) overlaps nothing: after 12 cycles alive is unchanged, score is unchanged and there are no pulses.
- Clear all 10 bricks over successive frames: all_clear=1 and score=10. new_level then gives alive=10'h3FF, all_clear=0 and score=10.
- Mid-operation events:
  - frame_tick at t+3 of an active scan is ignored.
  - rst asserted at t+5 gives IDLE, alive=10'h3FF and score=0 on the next cycle, with no bounce pulse.
